// File: rtl/rf_wb_arbiter.sv
// Round-robin arbiter for the single register-file write port (ALU vs LSU writeback).
// Optional forwarding path around the register file enabled by defining RF_WB_FWD_EN.
module rf_wb_arbiter #(
    parameter int unsigned REG_WIDTH = 64,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req0_valid,
    input  logic [4:0]           req0_rd,
    input  logic [REG_WIDTH-1:0] req0_data,
    output logic                 req0_ready,
    input  logic                 req1_valid,
    input  logic [4:0]           req1_rd,
    input  logic [REG_WIDTH-1:0] req1_data,
    output logic                 req1_ready,
    output logic [4:0]           wb_rd,
    output logic [REG_WIDTH-1:0] wb_din,
    output logic                 wb_reg_write,
    output logic [CNT_WIDTH-1:0] conflict_cnt
`ifdef RF_WB_FWD_EN
    ,
    input  logic [4:0]           rs1,
    input  logic [4:0]           rs2,
    input  logic [REG_WIDTH-1:0] rf_rs1_dout,
    input  logic [REG_WIDTH-1:0] rf_rs2_dout,
    output logic [REG_WIDTH-1:0] rs1_fwd,
    output logic [REG_WIDTH-1:0] rs2_fwd
`endif
);

    typedef enum logic {
        PRI_REQ0 = 1'b0,
        PRI_REQ1 = 1'b1
    } rr_ptr_t;

    rr_ptr_t rr_ptr;
    logic    both_valid;
    logic    grant0;
    logic    grant1;

    // Readys are held low while reset is asserted, even though they are combinational.
    always_comb begin
        both_valid = req0_valid && req1_valid;
        grant0     = 1'b0;
        grant1     = 1'b0;
        if (rst_n) begin
            if (both_valid) begin
                grant0 = (rr_ptr == PRI_REQ0);
                grant1 = (rr_ptr == PRI_REQ1);
            end else begin
                grant0 = req0_valid;
                grant1 = req1_valid;
            end
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr       <= PRI_REQ0;
            wb_reg_write <= 1'b0;
            wb_rd        <= '0;
            wb_din       <= '0;
            conflict_cnt <= '0;
        end else begin
            if (grant0) begin
                wb_rd        <= req0_rd;
                wb_din       <= req0_data;
                wb_reg_write <= (req0_rd != 5'd0);
            end else if (grant1) begin
                wb_rd        <= req1_rd;
                wb_din       <= req1_data;
                wb_reg_write <= (req1_rd != 5'd0);
            end else begin
                wb_reg_write <= 1'b0;
            end

            // Only a both-valid cycle leaves a requester waiting and moves the pointer.
            if (both_valid) begin
                rr_ptr <= grant0 ? PRI_REQ1 : PRI_REQ0;
                if (conflict_cnt != '1) begin
                    conflict_cnt <= conflict_cnt + 1'b1;
                end
            end
        end
    end

`ifdef RF_WB_FWD_EN
    always_comb begin
        rs1_fwd = rf_rs1_dout;
        rs2_fwd = rf_rs2_dout;
        if (wb_reg_write && (wb_rd == rs1) && (rs1 != 5'd0)) begin
            rs1_fwd = wb_din;
        end
        if (wb_reg_write && (wb_rd == rs2) && (rs2 != 5'd0)) begin
            rs2_fwd = wb_din;
        end
    end
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: directed vector table, saturation/reset sequences and
// randomized traffic against a cycle-level reference model (RF_WB_FWD_EN optional).
module tb_rf_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic [4:0]  req0_rd, req1_rd;
    logic [63:0] req0_data, req1_data;
    logic        req0_ready, req1_ready, r0_4, r1_4;
    logic [4:0]  wb_rd, wb_rd4;
    logic [63:0] wb_din, wb_din4;
    logic        wb_reg_write, wb_w4;
    logic [15:0] conflict_cnt;
    logic [3:0]  cnt4;
`ifdef RF_WB_FWD_EN
    logic [4:0]  rs1, rs2;
    logic [63:0] rf_rs1_dout, rf_rs2_dout, rs1_fwd, rs2_fwd, rs1_fwd4, rs2_fwd4;
`endif

    always #5 clk = ~clk;

    rf_wb_arbiter #(.REG_WIDTH(64), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_rd(req0_rd), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_rd(req1_rd), .req1_data(req1_data), .req1_ready(req1_ready),
        .wb_rd(wb_rd), .wb_din(wb_din), .wb_reg_write(wb_reg_write), .conflict_cnt(conflict_cnt)
`ifdef RF_WB_FWD_EN
        , .rs1(rs1), .rs2(rs2), .rf_rs1_dout(rf_rs1_dout), .rf_rs2_dout(rf_rs2_dout),
        .rs1_fwd(rs1_fwd), .rs2_fwd(rs2_fwd)
`endif
    );

    rf_wb_arbiter #(.REG_WIDTH(64), .CNT_WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_rd(req0_rd), .req0_data(req0_data), .req0_ready(r0_4),
        .req1_valid(req1_valid), .req1_rd(req1_rd), .req1_data(req1_data), .req1_ready(r1_4),
        .wb_rd(wb_rd4), .wb_din(wb_din4), .wb_reg_write(wb_w4), .conflict_cnt(cnt4)
`ifdef RF_WB_FWD_EN
        , .rs1(rs1), .rs2(rs2), .rf_rs1_dout(rf_rs1_dout), .rf_rs2_dout(rf_rs2_dout),
        .rs1_fwd(rs1_fwd4), .rs2_fwd(rs2_fwd4)
`endif
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: who is owed the next tie, what was last written, how many stalls.
    int          turn;
    int          m_grant;
    bit          m_known = 1'b0;
    logic        m_w;
    logic [4:0]  m_rd;
    logic [63:0] m_din;
    int          m_cnt, m_cnt4;

    task automatic apply(input logic rst, input logic v0, input logic [4:0] rd0, input logic [63:0] d0,
                         input logic v1, input logic [4:0] rd1, input logic [63:0] d1);
        logic [4:0]  rds[2];
        logic [63:0] ds[2];
        @(posedge clk);
        #1;
        rst_n = rst;
        req0_valid = v0; req0_rd = rd0; req0_data = d0;
        req1_valid = v1; req1_rd = rd1; req1_data = d1;
`ifdef RF_WB_FWD_EN
        rs1 = 5'($urandom % 8);
        rs2 = 5'($urandom % 8);
        rf_rs1_dout = {$urandom, $urandom};
        rf_rs2_dout = {$urandom, $urandom};
`endif
        rds[0] = rd0; rds[1] = rd1; ds[0] = d0; ds[1] = d1;
        m_grant = -1;
        if (rst) begin
            if (v0 && v1) m_grant = turn;
            else if (v0) m_grant = 0;
            else if (v1) m_grant = 1;
        end
        @(negedge clk);
        chk("req0_ready", req0_ready, m_grant == 0);
        chk("req1_ready", req1_ready, m_grant == 1);
        chk("req0_ready_w4", r0_4, m_grant == 0);
        if (m_known) begin
            chk("wb_reg_write", wb_reg_write, m_w);
            chk("wb_rd", wb_rd, m_rd);
            chk("wb_din", wb_din, m_din);
            chk("conflict_cnt", conflict_cnt, m_cnt);
            chk("conflict_cnt_w4", cnt4, m_cnt4);
`ifdef RF_WB_FWD_EN
            chk("rs1_fwd", rs1_fwd, (m_w && m_rd == rs1 && rs1 != 0) ? m_din : rf_rs1_dout);
            chk("rs2_fwd", rs2_fwd, (m_w && m_rd == rs2 && rs2 != 0) ? m_din : rf_rs2_dout);
`endif
        end
        if (!rst) begin
            m_known = 1'b1;
            m_w = 1'b0; m_rd = '0; m_din = '0;
            m_cnt = 0; m_cnt4 = 0; turn = 0;
        end else begin
            if (m_grant >= 0) begin
                m_rd  = rds[m_grant];
                m_din = ds[m_grant];
                m_w   = (rds[m_grant] != 0);
            end else begin
                m_w = 1'b0;
            end
            if (v0 && v1) begin
                m_cnt  = (m_cnt  < 65535) ? m_cnt + 1  : 65535;
                m_cnt4 = (m_cnt4 < 15)    ? m_cnt4 + 1 : 15;
                turn   = 1 - m_grant;
            end
        end
    endtask

    typedef struct {
        logic        rst;
        logic        v0;
        logic [4:0]  rd0;
        logic [63:0] d0;
        logic        v1;
        logic [4:0]  rd1;
        logic [63:0] d1;
        logic        r0, r1;
        logic        chk_reg;
        logic        w;
        logic [4:0]  rd;
        logic [63:0] din;
        int          cnt;
    } vec_t;

    function automatic vec_t mk(input logic rst, input logic v0, input logic [4:0] rd0, input logic [63:0] d0,
                                input logic v1, input logic [4:0] rd1, input logic [63:0] d1,
                                input logic r0, input logic r1, input logic cr, input logic w,
                                input logic [4:0] rd, input logic [63:0] din, input int cnt);
        vec_t v;
        v.rst = rst; v.v0 = v0; v.rd0 = rd0; v.d0 = d0; v.v1 = v1; v.rd1 = rd1; v.d1 = d1;
        v.r0 = r0; v.r1 = r1; v.chk_reg = cr; v.w = w; v.rd = rd; v.din = din; v.cnt = cnt;
        return v;
    endfunction

    vec_t vecs[21];
    logic        hold0, hold1;
    logic        rv0, rv1;
    logic [4:0]  rrd0, rrd1;
    logic [63:0] rd0d, rd1d;

    initial begin
        rst_n = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_rd = '0; req1_rd = '0; req0_data = '0; req1_data = '0;
`ifdef RF_WB_FWD_EN
        rs1 = '0; rs2 = '0; rf_rs1_dout = '0; rf_rs2_dout = '0;
`endif
        // Registered expectations in each row show the result of the previous row.
        vecs[0]  = mk(0, 1,1,64'h11, 1,2,64'h22, 0,0, 0, 0,0,64'h0,  0);
        vecs[1]  = mk(0, 1,1,64'h11, 1,2,64'h22, 0,0, 1, 0,0,64'h0,  0);
        vecs[2]  = mk(0, 1,1,64'h11, 1,2,64'h22, 0,0, 1, 0,0,64'h0,  0);
        vecs[3]  = mk(1, 1,1,64'h11, 1,2,64'h22, 1,0, 1, 0,0,64'h0,  0);
        vecs[4]  = mk(1, 1,1,64'h11, 1,2,64'h22, 0,1, 1, 1,1,64'h11, 1);
        vecs[5]  = mk(1, 1,1,64'h11, 1,2,64'h22, 1,0, 1, 1,2,64'h22, 2);
        vecs[6]  = mk(1, 1,1,64'h11, 1,2,64'h22, 0,1, 1, 1,1,64'h11, 3);
        vecs[7]  = mk(1, 1,1,64'h11, 1,2,64'h22, 1,0, 1, 1,2,64'h22, 4);
        vecs[8]  = mk(1, 1,1,64'h11, 1,2,64'h22, 0,1, 1, 1,1,64'h11, 5);
        vecs[9]  = mk(1, 1,5,64'hA5, 0,0,64'h0,  1,0, 1, 1,2,64'h22, 6);
        vecs[10] = mk(1, 0,0,64'h0,  0,0,64'h0,  0,0, 1, 1,5,64'hA5, 6);
        vecs[11] = mk(1, 0,0,64'h0,  1,0,64'hFFFF, 0,1, 1, 0,5,64'hA5, 6);
        vecs[12] = mk(1, 0,0,64'h0,  0,0,64'h0,  0,0, 1, 0,0,64'hFFFF, 6);
        vecs[13] = mk(1, 0,0,64'h0,  1,3,64'h33, 0,1, 1, 0,0,64'hFFFF, 6);
        vecs[14] = mk(1, 1,4,64'h44, 1,4,64'h45, 1,0, 1, 1,3,64'h33, 6);
        vecs[15] = mk(1, 1,6,64'h66, 1,4,64'h45, 0,1, 1, 1,4,64'h44, 7);
        vecs[16] = mk(1, 1,6,64'h66, 0,0,64'h0,  1,0, 1, 1,4,64'h45, 8);
        vecs[17] = mk(0, 1,1,64'h11, 1,2,64'h22, 0,0, 1, 1,6,64'h66, 8);
        vecs[18] = mk(1, 0,0,64'h0,  0,0,64'h0,  0,0, 1, 0,0,64'h0,  0);
        vecs[19] = mk(1, 1,1,64'h11, 1,2,64'h22, 1,0, 1, 0,0,64'h0,  0);
        vecs[20] = mk(1, 0,0,64'h0,  0,0,64'h0,  0,0, 1, 1,1,64'h11, 1);

        for (int i = 0; i < 21; i++) begin
            apply(vecs[i].rst, vecs[i].v0, vecs[i].rd0, vecs[i].d0, vecs[i].v1, vecs[i].rd1, vecs[i].d1);
            chk($sformatf("vec%0d_ready0", i), req0_ready, vecs[i].r0);
            chk($sformatf("vec%0d_ready1", i), req1_ready, vecs[i].r1);
            if (vecs[i].chk_reg) begin
                chk($sformatf("vec%0d_wbw", i), wb_reg_write, vecs[i].w);
                chk($sformatf("vec%0d_wbrd", i), wb_rd, vecs[i].rd);
                chk($sformatf("vec%0d_wbdin", i), wb_din, vecs[i].din);
                chk($sformatf("vec%0d_cnt", i), conflict_cnt, vecs[i].cnt);
            end
        end

        // Saturation of the 4-bit counter, then reset on the cycle after a grant.
        apply(0, 0,0,64'h0, 0,0,64'h0);
        for (int i = 0; i < 20; i++) apply(1, 1,1,64'h11, 1,2,64'h22);
        apply(1, 0,0,64'h0, 0,0,64'h0);
        chk("sat_cnt4", cnt4, 4'd15);
        chk("sat_cnt16", conflict_cnt, 16'd20);
        apply(1, 1,9,64'h99, 0,0,64'h0);
        apply(0, 0,0,64'h0, 0,0,64'h0);
        apply(1, 0,0,64'h0, 0,0,64'h0);
        chk("midrst_wbw", wb_w4, 1'b0);
        chk("midrst_cnt4", cnt4, 4'd0);

`ifdef RF_WB_FWD_EN
        apply(1, 1,7,64'h1234, 0,0,64'h0);
        apply(1, 0,0,64'h0, 0,0,64'h0);
        rs1 = 5'd7; rs2 = 5'd0; rf_rs1_dout = 64'hDEAD; rf_rs2_dout = 64'h55;
        #1;
        chk("fwd_rs1", rs1_fwd, 64'h1234);
        chk("fwd_rs2", rs2_fwd, 64'h55);
`endif

        // Randomized traffic; requesters hold their request until accepted.
        hold0 = 1'b0; hold1 = 1'b0;
        rv0 = 1'b0; rv1 = 1'b0; rrd0 = '0; rrd1 = '0; rd0d = '0; rd1d = '0;
        for (int i = 0; i < 400; i++) begin
            if (!hold0) begin
                rv0 = ($urandom % 3) != 0; rrd0 = 5'($urandom % 32); rd0d = {$urandom, $urandom};
            end
            if (!hold1) begin
                rv1 = ($urandom % 3) != 0; rrd1 = 5'($urandom % 32); rd1d = {$urandom, $urandom};
            end
            apply(($urandom % 40) != 0, rv0, rrd0, rd0d, rv1, rrd1, rd1d);
            hold0 = rv0 && (m_grant != 0);
            hold1 = rv1 && (m_grant != 1);
        end
        apply(1, 0,0,64'h0, 0,0,64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
